// File: rtl/m31_pkg.sv
// m31_pkg: Mersenne-31 constants, op encoding and 32-to-31-bit canonical reduction shared by the add/sub pipeline
package m31_pkg;
    localparam int M31_WIDTH = 31;
    localparam logic [M31_WIDTH-1:0] M31_P = 31'h7FFFFFFF;
    typedef enum logic [1:0] {ADD, SUB, RSUB, PASS} m31_addsub_op_e;
    function automatic logic [M31_WIDTH-1:0] m31_reduce32(input logic [M31_WIDTH:0] s);
        logic [M31_WIDTH-1:0] r;
        r = s[M31_WIDTH-1:0] + M31_WIDTH'(s[M31_WIDTH]);
        return r == M31_P ? '0 : r;
    endfunction
endpackage

// File: rtl/m31_addsub_lane.sv
// m31_addsub_lane: one lane; a/b/op/en -> 32-bit raw sum (stage-1 input), s/s_en -> canonical or raw-passthrough word r (stage-2 input)
module m31_addsub_lane
    import m31_pkg::*;
(
    input  logic [M31_WIDTH-1:0] a,
    input  logic [M31_WIDTH-1:0] b,
    input  m31_addsub_op_e       op,
    input  logic                 en,
    output logic [M31_WIDTH:0]   sum,
    input  logic [M31_WIDTH:0]   s,
    input  logic                 s_en,
    output logic [M31_WIDTH-1:0] r
);
    logic [M31_WIDTH-1:0] x, y;
    always_comb begin
        x = op == RSUB ? M31_P - a : a;
        y = op == SUB ? M31_P - b : op == PASS ? '0 : b;
        sum = en ? {1'b0, x} + {1'b0, y} : {1'b0, a};
        r = s_en ? m31_reduce32(s) : s[M31_WIDTH-1:0];
    end
endmodule

// File: rtl/m31_vector_addsub_pipe.sv
// m31_vector_addsub_pipe: 2-stage stall-in-place M31 vector add/sub/rsub/pass; in_valid/in_ready/in_op/in_lane_en/in_tag/vec1/vec2 in, out_valid/out_ready/out_tag/result out
module m31_vector_addsub_pipe
    import m31_pkg::*;
#(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [VECTOR_SIZE-1:0] in_lane_en,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic [WORD_WIDTH-1:0]  vec1 [0:VECTOR_SIZE-1],
    input  logic [WORD_WIDTH-1:0]  vec2 [0:VECTOR_SIZE-1],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic [WORD_WIDTH-1:0]  result [0:VECTOR_SIZE-1]
);
    if (WORD_WIDTH != M31_WIDTH) begin : g_bad_width
        $error("WORD_WIDTH must be 31 for M31 reduction");
    end
    if (VECTOR_SIZE < 1 || VECTOR_SIZE > 64) begin : g_bad_size
        $error("VECTOR_SIZE must be in 1..64");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
        $error("TAG_WIDTH must be >= 1");
    end
    logic s1_valid, s2_valid, s1_load, s2_load;
    logic [VECTOR_SIZE-1:0] s1_en;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic [WORD_WIDTH:0] s1_sum [0:VECTOR_SIZE-1];
    logic [WORD_WIDTH:0] sum_w [0:VECTOR_SIZE-1];
    logic [WORD_WIDTH-1:0] red_w [0:VECTOR_SIZE-1];
    assign s2_load = !s2_valid | out_ready;
    assign s1_load = !s1_valid | s2_load;
    assign in_ready = s1_load;
    assign out_valid = s2_valid;
    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_lane
        m31_addsub_lane u_lane (
            .a    (vec1[i]),
            .b    (vec2[i]),
            .op   (m31_addsub_op_e'(in_op)),
            .en   (in_lane_en[i]),
            .sum  (sum_w[i]),
            .s    (s1_sum[i]),
            .s_en (s1_en[i]),
            .r    (red_w[i])
        );
    end
    // disabled lanes carry the raw vec1 word through s1_sum, so no extra operand storage is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_en <= '0;
            s1_tag <= '0;
            out_tag <= '0;
            for (int k = 0; k < VECTOR_SIZE; k++) begin
                s1_sum[k] <= '0;
                result[k] <= '0;
            end
        end else begin
            if (s1_load) s1_valid <= in_valid;
            if (s1_load && in_valid) begin
                s1_en <= in_lane_en;
                s1_tag <= in_tag;
                s1_sum <= sum_w;
            end
            if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                out_tag <= s1_tag;
                result <= red_w;
            end
        end
    end
endmodule

// File: tb/tb_m31_vector_addsub_pipe.sv
// tb_m31_vector_addsub_pipe: directed and reference-model checks of the M31 vector add/sub pipeline
module tb_m31_vector_addsub_pipe;
    localparam int N = 16;
    localparam logic [30:0] P = 31'h7FFFFFFF;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_op;
    logic [N-1:0] in_lane_en;
    logic [3:0] in_tag, out_tag;
    logic [30:0] vec1 [0:N-1];
    logic [30:0] vec2 [0:N-1];
    logic [30:0] result [0:N-1];
    logic [30:0] exp_r [0:99][0:N-1];
    logic [3:0] exp_tag [0:99];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    m31_vector_addsub_pipe #(.WORD_WIDTH(31), .VECTOR_SIZE(N), .TAG_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_lane_en (in_lane_en),
        .in_tag     (in_tag),
        .vec1       (vec1),
        .vec2       (vec2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .result     (result)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [30:0] model(input logic [30:0] a, input logic [30:0] b, input logic [1:0] op, input logic en);
        longint p, x, y, r;
        p = 64'h7FFFFFFF;
        x = longint'(a) % p;
        y = longint'(b) % p;
        if (!en) return a;
        case (op)
            2'd0: r = (x + y) % p;
            2'd1: r = (x - y + p) % p;
            2'd2: r = (y - x + p) % p;
            default: r = x;
        endcase
        return r[30:0];
    endfunction
    function automatic logic [30:0] rnd_word();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? P : k == 1 ? P - 31'd1 : k == 2 ? 31'd0 : 31'($urandom);
    endfunction
    task automatic set_all(input logic [30:0] a, input logic [30:0] b);
        for (int l = 0; l < N; l++) begin
            vec1[l] = a;
            vec2[l] = b;
        end
    endtask
    task automatic run_vec(input logic [1:0] op, input logic [N-1:0] en, input logic [3:0] tag, input string name);
        in_op = op;
        in_lane_en = en;
        in_tag = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask
    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int sent, recv, got, stalls;
        logic saw_full, stall_prev;
        logic [3:0] prev_tag;
        logic [30:0] prev_r;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_op = 2'd0;
        in_lane_en = '1;
        in_tag = 4'd0;
        set_all(31'd0, 31'd0);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(result[0]), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("empty_in_ready", 64'(in_ready), 64'd1);
        vec1[0] = P - 31'd1;
        vec2[0] = 31'd1;
        vec1[1] = P - 31'd1;
        vec2[1] = P - 31'd1;
        run_vec(2'd0, '1, 4'd3, "add");
        chk("add_wrap0", 64'(result[0]), 64'd0);
        chk("add_wrap1", 64'(result[1]), 64'h7FFFFFFD);
        tick();
        chk("add_drain", 64'(out_valid), 64'd0);
        vec1[0] = 31'd5;
        vec2[0] = 31'd7;
        vec1[1] = P;
        vec2[1] = P;
        run_vec(2'd1, '1, 4'd4, "sub");
        chk("sub_5_7", 64'(result[0]), 64'h7FFFFFFD);
        chk("sub_p_p", 64'(result[1]), 64'd0);
        run_vec(2'd2, '1, 4'd5, "rsub");
        chk("rsub_5_7", 64'(result[0]), 64'd2);
        vec1[0] = P;
        vec1[1] = 31'd5;
        vec2[0] = 31'd9;
        vec2[1] = 31'd9;
        run_vec(2'd3, '1, 4'd6, "pass");
        chk("pass_p", 64'(result[0]), 64'd0);
        chk("pass_5", 64'(result[1]), 64'd5);
        set_all(P, 31'd3);
        run_vec(2'd0, 16'h00FF, 4'd7, "mask");
        for (int l = 0; l < N; l++) chk($sformatf("mask_lane%0d", l), 64'(result[l]), l < 8 ? 64'd3 : 64'(P));
        tick();
        sent = 0;
        recv = 0;
        saw_full = 1'b0;
        stall_prev = 1'b0;
        prev_tag = '0;
        prev_r = '0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 5) begin
                in_valid = 1'b1;
                in_op = 2'd0;
                in_lane_en = '1;
                in_tag = 4'(sent + 1);
                for (int l = 0; l < N; l++) begin
                    vec1[l] = 31'(sent + 1);
                    vec2[l] = 31'(l);
                end
            end else in_valid = 1'b0;
            #1;
            if (!in_ready) saw_full = 1'b1;
            if (stall_prev) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_tag", 64'(out_tag), 64'(prev_tag));
                chk("bp_hold_r", 64'(result[5]), 64'(prev_r));
            end
            stall_prev = out_valid && !out_ready;
            prev_tag = out_tag;
            prev_r = result[5];
            if (out_valid && out_ready) begin
                chk("bp_tag", 64'(out_tag), 64'(recv + 1));
                chk("bp_r5", 64'(result[5]), 64'(recv + 6));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        chk("bp_count", 64'(recv), 64'd5);
        chk("bp_full", 64'(saw_full), 64'd1);
        out_ready = 1'b1;
        got = 0;
        stalls = 0;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                for (int l = 0; l < N; l++) begin
                    vec1[l] = rnd_word();
                    vec2[l] = rnd_word();
                end
                in_op = 2'($urandom);
                in_lane_en = N'($urandom);
                in_tag = c[3:0];
                in_valid = 1'b1;
                for (int l = 0; l < N; l++) exp_r[c][l] = model(vec1[l], vec2[l], in_op, in_lane_en[l]);
                exp_tag[c] = in_tag;
            end else in_valid = 1'b0;
            #1;
            if (!in_ready) stalls++;
            if (out_valid && got < 100) begin
                for (int l = 0; l < N; l++) chk($sformatf("rnd%0d_lane%0d", got, l), 64'(result[l]), 64'(exp_r[got][l]));
                chk("rnd_tag", 64'(out_tag), 64'(exp_tag[got]));
                got++;
            end
            tick();
        end
        chk("rnd_count", 64'(got), 64'd100);
        chk("rnd_stalls", 64'(stalls), 64'd0);
        tick();
        set_all(31'd1, 31'd1);
        in_op = 2'd0;
        in_lane_en = '1;
        in_tag = 4'd9;
        in_valid = 1'b1;
        tick();
        in_tag = 4'd10;
        tick();
        in_valid = 1'b0;
        chk("rst_inflight", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(result[0]), 64'd0);
        chk("rst_mid_tag", 64'(out_tag), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_stale", 64'(out_valid), 64'd0);
        vec1[0] = 31'd10;
        vec2[0] = 31'd20;
        run_vec(2'd0, '1, 4'd11, "post_rst");
        chk("post_rst_r0", 64'(result[0]), 64'd30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
